// File: rtl/cpen391_group5_qsys_timer_mc.sv
// Multi-channel Avalon-MM down-counting timer with per-channel timeout pulse and irq.
// Define TIMER_MC_PRESCALE_EN to build in the per-channel clock prescaler (CONTROL[15:8]).

module cpen391_group5_qsys_timer_mc_ch #(
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [1:0]  reg_sel,
    input  logic [31:0] wdata,
    output logic [31:0] rd_data,
    output logic        tick,
    output logic        irq_req
);
    logic             run, run_nxt, to, ito, cont;
    logic [CNT_W-1:0] period, cnt, snapshot;
    logic [7:0]       pre;
    logic             ce, timeout;
    logic             wr_status, wr_ctrl, wr_period, wr_snap, start, stop;
    logic             unused_wdata;

    assign unused_wdata = ^wdata;

    assign wr_status = wr_en && (reg_sel == 2'd0);
    assign wr_ctrl   = wr_en && (reg_sel == 2'd1);
    assign wr_period = wr_en && (reg_sel == 2'd2);
    assign wr_snap   = wr_en && (reg_sel == 2'd3);
    assign start     = wr_ctrl && wdata[2];
    assign stop      = wr_ctrl && wdata[3];
    assign timeout   = run && ce && (cnt == '0);
    assign irq_req   = to && ito;

    // Later terms win: STOP beats START, a PERIOD write beats everything.
    always_comb begin
        run_nxt = run;
        if (timeout && !cont) run_nxt = 1'b0;
        if (start)            run_nxt = 1'b1;
        if (stop)             run_nxt = 1'b0;
        if (wr_period)        run_nxt = 1'b0;
    end

`ifdef TIMER_MC_PRESCALE_EN
    logic [7:0] pcnt;

    assign ce = (pcnt >= pre);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt <= '0;
            pre  <= '0;
        end else begin
            if (wr_ctrl) pre <= wdata[15:8];
            if (start || wr_period || !run_nxt) pcnt <= '0;
            else if (run)                       pcnt <= ce ? 8'd0 : pcnt + 8'd1;
        end
    end
`else
    assign pre = '0;
    assign ce  = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run      <= 1'b0;
            to       <= 1'b0;
            ito      <= 1'b0;
            cont     <= 1'b0;
            tick     <= 1'b0;
            period   <= CNT_W'(RESET_PERIOD);
            cnt      <= CNT_W'(RESET_PERIOD);
            snapshot <= '0;
        end else begin
            run  <= run_nxt;
            tick <= timeout;
            if (wr_ctrl) begin
                ito  <= wdata[0];
                cont <= wdata[1];
            end
            if (timeout)        to <= 1'b1;
            else if (wr_status) to <= 1'b0;
            if (wr_period) period   <= wdata[CNT_W-1:0];
            if (wr_snap)   snapshot <= cnt;
            if (wr_period)       cnt <= wdata[CNT_W-1:0];
            else if (timeout)    cnt <= period;
            else if (run && ce)  cnt <= cnt - CNT_W'(1);
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd0:    rd_data = {30'd0, run, to};
            2'd1:    rd_data = {16'd0, pre, 6'd0, cont, ito};
            2'd2:    rd_data = 32'(period);
            default: rd_data = 32'(snapshot);
        endcase
    end
endmodule

module cpen391_group5_qsys_timer_mc #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49999,
    parameter int AW           = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] tick_out
);
    localparam int CHW = AW - 2;

    logic [CHW-1:0]           sel_ch;
    logic [1:0]               sel_reg;
    logic [NUM_CH-1:0][31:0]  ch_rd;
    logic [NUM_CH-1:0]        ch_irq, ch_wr;
    logic [31:0]              rd_mux;

    assign sel_ch  = address[AW-1:2];
    assign sel_reg = address[1:0];

    // Channel indices >= NUM_CH match no instance, so they neither write nor read.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_wr[i] = chipselect && !write_n && (sel_ch == CHW'(i));

        cpen391_group5_qsys_timer_mc_ch #(
            .CNT_W        (CNT_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_en   (ch_wr[i]),
            .reg_sel (sel_reg),
            .wdata   (writedata),
            .rd_data (ch_rd[i]),
            .tick    (tick_out[i]),
            .irq_req (ch_irq[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (sel_ch == CHW'(i)) rd_mux = ch_rd[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

    assign irq = |ch_irq;
endmodule

// File: tb/tb_cpen391_group5_qsys_timer_mc.sv
// Bench for cpen391_group5_qsys_timer_mc: 4-channel DUT plus a 3-channel DUT on the same bus,
// checked every cycle against a behavioural model and by directed literal expectations.

module tb_cpen391_group5_qsys_timer_mc;
    localparam int RP = 49999;
`ifdef TIMER_MC_PRESCALE_EN
    localparam int          SP      = 6;
    localparam logic [31:0] CTRL_RB = 32'h203;
`else
    localparam int          SP      = 2;
    localparam logic [31:0] CTRL_RB = 32'h3;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata;
    logic [31:0] readdata, readdata2;
    logic        irq, irq2;
    logic [3:0]  tick_out;
    logic [2:0]  tick2;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int tcnt[4] = '{0, 0, 0, 0};
    logic chk_en = 1'b0;

    // behavioural model state
    logic        m_run[4], m_to[4], m_ito[4], m_cont[4];
    int unsigned m_per[4], m_cnt[4], m_snap[4], m_pre[4], m_div[4];
    logic [31:0] exp_rd = '0, exp_rd2 = '0;
    logic [3:0]  exp_tick = '0;
    logic        exp_irq = 1'b0, exp_irq2 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpen391_group5_qsys_timer_mc dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .tick_out(tick_out)
    );

    cpen391_group5_qsys_timer_mc #(.NUM_CH(3), .AW(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata2), .irq(irq2),
        .tick_out(tick2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mread(input int c, input int r);
        case (r)
            0:       return {30'd0, m_run[c], m_to[c]};
            1:       return {16'd0, 8'(m_pre[c]), 6'd0, m_cont[c], m_ito[c]};
            2:       return m_per[c];
            default: return m_snap[c];
        endcase
    endfunction

    task automatic model_step();
        int ach, areg;
        logic wr, fire, hit, nrun, strt;
        if (!reset_n) begin
            for (int c = 0; c < 4; c++) begin
                m_run[c] = 0; m_to[c] = 0; m_ito[c] = 0; m_cont[c] = 0;
                m_per[c] = RP; m_cnt[c] = RP; m_snap[c] = 0; m_pre[c] = 0; m_div[c] = 0;
            end
            exp_rd = 0; exp_rd2 = 0; exp_tick = 0; exp_irq = 0; exp_irq2 = 0;
            return;
        end
        ach  = int'(address[3:2]);
        areg = int'(address[1:0]);
        wr   = chipselect && !write_n;
        exp_rd  = mread(ach, areg);
        exp_rd2 = (ach == 3) ? 32'd0 : exp_rd;
        for (int c = 0; c < 4; c++) begin
            // m_div counts run clocks since the last (re)start; one count every PRE+1 of them
            fire = m_run[c] && ((m_div[c] % (m_pre[c] + 1)) == m_pre[c]);
            hit  = fire && (m_cnt[c] == 0);
            exp_tick[c] = hit;
            nrun = m_run[c];
            strt = 0;
            if (wr && ach == c && areg == 3) m_snap[c] = m_cnt[c];
            if (hit) begin
                m_to[c]  = 1;
                m_cnt[c] = m_per[c];
                if (!m_cont[c]) nrun = 0;
            end else if (fire) m_cnt[c] = m_cnt[c] - 1;
            if (wr && ach == c) begin
                case (areg)
                    0: if (!hit) m_to[c] = 0;
                    1: begin
                        m_ito[c]  = writedata[0];
                        m_cont[c] = writedata[1];
`ifdef TIMER_MC_PRESCALE_EN
                        m_pre[c]  = int'(writedata[15:8]);
`endif
                        if (writedata[2]) begin nrun = 1; strt = 1; end
                        if (writedata[3]) nrun = 0;
                    end
                    2: begin m_per[c] = writedata; m_cnt[c] = writedata; nrun = 0; end
                    default: ;
                endcase
            end
            if (!nrun || strt)  m_div[c] = 0;
            else if (m_run[c])  m_div[c] = m_div[c] + 1;
            m_run[c] = nrun;
        end
        exp_irq  = (m_to[0] & m_ito[0]) | (m_to[1] & m_ito[1]) | (m_to[2] & m_ito[2]) | (m_to[3] & m_ito[3]);
        exp_irq2 = (m_to[0] & m_ito[0]) | (m_to[1] & m_ito[1]) | (m_to[2] & m_ito[2]);
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        for (int c = 0; c < 4; c++) if (tick_out[c] === 1'b1) tcnt[c]++;
        if (chk_en) begin
            chk("readdata", readdata, exp_rd);
            chk("irq", {31'd0, irq}, {31'd0, exp_irq});
            chk("tick_out", {28'd0, tick_out}, {28'd0, exp_tick});
            chk("readdata_nch3", readdata2, exp_rd2);
            chk("irq_nch3", {31'd0, irq2}, {31'd0, exp_irq2});
            chk("tick_out_nch3", {29'd0, tick2}, {29'd0, exp_tick[2:0]});
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_wr(input int a, input logic [31:0] d);
        chipselect = 1; write_n = 0; address = 4'(a); writedata = d;
        @(posedge clk); #1;
        chipselect = 0; write_n = 1; writedata = '0;
    endtask

    task automatic bus_rd(input int a, output logic [31:0] d);
        chipselect = 1; write_n = 1; address = 4'(a);
        @(posedge clk); #1;
        d = readdata;
        chipselect = 0;
    endtask

    task automatic wait_tick(input int c, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (tick_out[c]) begin at = cyc; break; end
        end
        if (at < 0) begin
            n_chk++; n_fail++;
            $display("FAIL wait_tick ch%0d: no pulse within 40 cycles, required one", c);
        end
    endtask

    initial begin
        int s, t1, t2, n0;
        logic [31:0] d;
        chipselect = 0; write_n = 1; address = '0; writedata = '0;
        @(posedge clk); #1;
        chk_en = 1;
        step(2);
        reset_n = 1;
        bus_rd(2, d);  chk("rst_period", d, RP);
        bus_rd(0, d);  chk("rst_status", d, 0);
        chk("rst_irq", {31'd0, irq}, 0);

        // ch0 continuous, period 3, irq enabled
        bus_wr(2, 3); bus_wr(1, 7); s = cyc;
        wait_tick(0, t1); chk("c0_first", t1 - s, 4);
        wait_tick(0, t2); chk("c0_period", t2 - t1, 4);
        chk("c0_irq", {31'd0, irq}, 1);
        bus_rd(0, d); chk("c0_status", d, 3);

        // STATUS write colliding with a timeout, then a clean clear
        wait_tick(0, t1);
        step(3);
        bus_wr(0, 0);
        chk("to_race_tick", {31'd0, tick_out[0]}, 1);
        chk("to_race_irq", {31'd0, irq}, 1);
        bus_wr(0, 0);
        chk("to_clear_irq", {31'd0, irq}, 0);
        bus_wr(1, 32'h8); bus_wr(1, 32'hC);
        bus_rd(0, d); chk("start_stop_run", d & 32'h2, 0);

        // ch1 one-shot
        n0 = tcnt[1];
        bus_wr(6, 5); bus_wr(5, 5); s = cyc;
        wait_tick(1, t1); chk("c1_oneshot_lat", t1 - s, 6);
        step(10);
        chk("c1_one_pulse", tcnt[1] - n0, 1);
        bus_rd(4, d); chk("c1_status", d, 1);
        bus_wr(7, 0); bus_rd(7, d); chk("c1_snapshot", d, 5);

        // ch2 PERIOD=0 continuous, then PERIOD write on a timeout
        bus_wr(10, 0); bus_wr(9, 6); s = cyc;
        wait_tick(2, t1); chk("p0_first", t1 - s, 1);
        wait_tick(2, t2); chk("p0_every", t2 - t1, 1);
        bus_wr(10, 7);
        chk("pw_race_tick", {31'd0, tick_out[2]}, 1);
        bus_rd(8, d); chk("pw_race_status", d, 1);
        bus_wr(11, 0); bus_rd(11, d); chk("pw_race_cnt", d, 7);

        // START while running leaves the count alone
        bus_wr(9, 6); s = cyc;
        step(2);
        bus_wr(9, 6);
        wait_tick(2, t1); chk("restart_ignored", t1 - s, 8);

        // ch3 exists only on the 4-channel DUT
        bus_wr(14, 32'h1234); bus_wr(15, 0);
        bus_rd(15, d); chk("c3_snap", d, 32'h1234);
        chk("nch3_c3_snap", readdata2, 0);
        bus_rd(14, d); chk("nch3_c3_period", readdata2, 0);
        bus_rd(6, d);  chk("nch3_c1_period", readdata2, 5);

        // prescaler behaviour (or its absence)
        bus_wr(14, 1); bus_wr(13, 32'h207); s = cyc;
        wait_tick(3, t1); chk("pre_first", t1 - s, SP);
        wait_tick(3, t2); chk("pre_period", t2 - t1, SP);
        bus_rd(13, d); chk("pre_ctrl", d, CTRL_RB);

        // asynchronous reset mid-count
        #2 reset_n = 0;
        #1;
        chk("arst_readdata", readdata, 0);
        chk("arst_irq", {31'd0, irq}, 0);
        chk("arst_tick", {28'd0, tick_out}, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1;
        n0 = tcnt[0] + tcnt[1] + tcnt[2] + tcnt[3];
        step(20);
        chk("arst_no_tick", tcnt[0] + tcnt[1] + tcnt[2] + tcnt[3] - n0, 0);
        bus_rd(10, d); chk("arst_period", d, RP);
        bus_rd(8, d);  chk("arst_status", d, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
